// File: rtl/nios_i2c_acc_pkg.sv
// rtl/nios_i2c_acc_pkg.sv - shared FSM encoding and PIO register offsets for the switch poller
package nios_i2c_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_LAT  = 2'd2,
        ST_CAP  = 2'd3
    } poll_state_e;

    localparam logic [1:0] PIO_DATA_OFS = 2'd0;

endpackage

// File: rtl/nios_i2c_acc_poll_timer.sv
// rtl/nios_i2c_acc_poll_timer.sv - free-running divider with run gate and terminal-count pulse
module nios_i2c_acc_poll_timer #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run_i,
    output logic tc_o
);

    localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counter parks at zero whenever it is not running, so each poll interval starts fresh.
    always_comb begin
        tc_o  = run_i && (cnt_q == CW'(DIV - 1));
        cnt_d = cnt_q;
        if (!run_i || tc_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nios_i2c_acc_pio_poller.sv
// rtl/nios_i2c_acc_pio_poller.sv - Avalon-MM read master that polls the switch PIO and flags changes
module nios_i2c_acc_pio_poller
    import nios_i2c_acc_pkg::*;
#(
    parameter int         DATA_WIDTH   = 10,
    parameter int         POLL_DIV     = 50000,
    parameter int         READ_LATENCY = 1,
    parameter int         TIMEOUT      = 255,
    parameter logic [1:0] REG_ADDR     = PIO_DATA_OFS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  clr_err,
    output logic [1:0]            m_address,
    output logic                  m_read,
    input  logic                  m_waitrequest,
    input  logic [31:0]           m_readdata,
    output logic [DATA_WIDTH-1:0] value,
    output logic                  value_valid,
    output logic                  changed,
    output logic                  timeout_err,
    output logic                  busy
);

    localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int LAT_W  = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

    poll_state_e           state_q, state_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [DATA_WIDTH-1:0] value_q, value_d;
    logic                  valid_q, valid_d;
    logic                  changed_q, changed_d;
    logic                  err_q, err_d;
    logic                  m_read_q, m_read_d;
    logic [1:0]            m_address_q;
    logic                  tick;
    logic                  timeout_hit;
    logic [DATA_WIDTH-1:0] sample;

    assign sample = m_readdata[DATA_WIDTH-1:0];

    generate
        if (DATA_WIDTH < 32) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^m_readdata[31:DATA_WIDTH];
        end
    endgenerate

    nios_i2c_acc_poll_timer #(
        .DIV (POLL_DIV)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .run_i   (enable && (state_q == ST_IDLE)),
        .tc_o    (tick)
    );

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        lat_d       = lat_q;
        value_d     = value_q;
        valid_d     = valid_q;
        changed_d   = 1'b0;
        err_d       = err_q;
        timeout_hit = 1'b0;

        case (state_q)
            ST_IDLE: begin
                wait_d = '0;
                lat_d  = '0;
                if (tick) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!m_waitrequest) begin
                    state_d = ST_LAT;
                    lat_d   = LAT_W'(1);
                    wait_d  = '0;
                end else if (wait_q == WAIT_W'(TIMEOUT)) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_IDLE;
                    wait_d      = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_LAT: begin
                if (lat_q == LAT_W'(READ_LATENCY)) begin
                    state_d = ST_CAP;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            ST_CAP: begin
                value_d   = sample;
                valid_d   = 1'b1;
                changed_d = valid_q && (sample != value_q);
                lat_d     = '0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A timeout in the same cycle as a clear must leave the error visible.
        if (timeout_hit) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end

        m_read_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            lat_q       <= '0;
            value_q     <= '0;
            valid_q     <= 1'b0;
            changed_q   <= 1'b0;
            err_q       <= 1'b0;
            m_read_q    <= 1'b0;
            m_address_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            lat_q       <= lat_d;
            value_q     <= value_d;
            valid_q     <= valid_d;
            changed_q   <= changed_d;
            err_q       <= err_d;
            m_read_q    <= m_read_d;
            m_address_q <= REG_ADDR;
        end
    end

    assign m_address   = m_address_q;
    assign m_read      = m_read_q;
    assign value       = value_q;
    assign value_valid = valid_q;
    assign changed     = changed_q;
    assign timeout_err = err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nios_i2c_acc_pio_poller.sv
// tb/tb_nios_i2c_acc_pio_poller.sv - directed self-checking bench for the switch PIO poller
module tb_nios_i2c_acc_pio_poller;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        clr_err;
    logic [1:0]  m_address;
    logic        m_read;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic [9:0]  value;
    logic        value_valid;
    logic        changed;
    logic        timeout_err;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int hi_cnt = 0;
    int chg_cnt = 0;
    int rise_cnt = 0;
    logic m_read_prev = 1'b0;

    int t0, h0, c0, r0;

    nios_i2c_acc_pio_poller #(
        .DATA_WIDTH   (10),
        .POLL_DIV     (8),
        .READ_LATENCY (1),
        .TIMEOUT      (4),
        .REG_ADDR     (2'd0)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .clr_err       (clr_err),
        .m_address     (m_address),
        .m_read        (m_read),
        .m_waitrequest (m_waitrequest),
        .m_readdata    (m_readdata),
        .value         (value),
        .value_valid   (value_valid),
        .changed       (changed),
        .timeout_err   (timeout_err),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_read) hi_cnt <= hi_cnt + 1;
        if (changed) chg_cnt <= chg_cnt + 1;
        if (m_read && !m_read_prev) rise_cnt <= rise_cnt + 1;
        m_read_prev <= m_read;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got time %0t required completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rise(input string tag, input int budget);
        int n;
        n = 0;
        while (m_read === 1'b1 && n < budget) begin
            step();
            n++;
        end
        while (m_read !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check(tag, m_read, 1'b1);
    endtask

    task automatic wait_fall(input string tag, input int budget);
        int n;
        n = 0;
        while (m_read === 1'b1 && n < budget) begin
            step();
            n++;
        end
        check(tag, m_read, 1'b0);
    endtask

    initial begin
        reset_n       = 1'b0;
        enable        = 1'b0;
        clr_err       = 1'b0;
        m_waitrequest = 1'b0;
        m_readdata    = 32'hFFFF_F2A5;
        repeat (5) step();
        check("rst m_read", m_read, 0);
        check("rst value", value, 0);
        check("rst valid", value_valid, 0);
        check("rst changed", changed, 0);
        check("rst err", timeout_err, 0);
        check("rst busy", busy, 0);
        check("rst addr", m_address, 0);

        reset_n = 1'b1;
        r0 = rise_cnt;
        repeat (100) step();
        check("idle no read", rise_cnt - r0, 0);
        check("idle busy", busy, 0);

        // basic poll; upper data bits must be ignored
        enable = 1'b1;
        wait_rise("poll1 rise", 40);
        t0 = cyc; h0 = hi_cnt; c0 = chg_cnt;
        step();
        check("poll1 read width", m_read, 0);
        repeat (2) step();
        check("poll1 value", value, 10'h2A5);
        check("poll1 valid", value_valid, 1);
        wait_rise("poll2 rise", 40);
        check("basic period", cyc - t0, 11);
        check("basic read cycles", hi_cnt - h0, 1);
        check("first capture no change", chg_cnt - c0, 0);

        // change detect
        m_readdata = 32'h0000_02A4;
        c0 = chg_cnt;
        wait_rise("poll3 rise", 40);
        check("change pulse", chg_cnt - c0, 1);
        check("change value", value, 10'h2A4);
        c0 = chg_cnt; t0 = cyc;
        wait_rise("poll4 rise", 40);
        check("no change pulse", chg_cnt - c0, 0);
        check("steady period", cyc - t0, 11);

        // three-cycle waitrequest stall
        repeat (4) step();
        m_waitrequest = 1'b1;
        m_readdata    = 32'h0000_0155;
        wait_rise("stall rise", 40);
        t0 = cyc; h0 = hi_cnt; c0 = chg_cnt;
        repeat (3) step();
        m_waitrequest = 1'b0;
        wait_rise("post stall rise", 40);
        check("stall read cycles", hi_cnt - h0, 4);
        check("stall period", cyc - t0, 14);
        check("stall value", value, 10'h155);
        check("stall change", chg_cnt - c0, 1);

        // timeout with waitrequest stuck
        repeat (4) step();
        m_waitrequest = 1'b1;
        m_readdata    = 32'h0000_03FF;
        wait_rise("timeout rise", 40);
        h0 = hi_cnt;
        wait_fall("timeout fall", 20);
        check("timeout read cycles", hi_cnt - h0, 5);
        check("timeout err", timeout_err, 1);
        check("timeout value kept", value, 10'h155);
        check("timeout busy", busy, 0);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("clr err", timeout_err, 0);

        // clear held across the next timeout: set wins
        clr_err = 1'b1;
        wait_rise("timeout2 rise", 40);
        wait_fall("timeout2 fall", 20);
        check("set beats clr", timeout_err, 1);
        clr_err = 1'b0;
        step();
        check("err sticky", timeout_err, 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("clr err again", timeout_err, 0);

        // enable dropped while in LAT
        m_waitrequest = 1'b0;
        m_readdata    = 32'h0000_00F0;
        wait_rise("midop rise", 40);
        step();
        enable = 1'b0;
        r0 = rise_cnt;
        repeat (30) step();
        check("midop capture", value, 10'h0F0);
        check("midop no read", rise_cnt - r0, 0);
        check("midop busy", busy, 0);

        // reset while in REQ
        m_waitrequest = 1'b1;
        enable        = 1'b1;
        wait_rise("reset rise", 40);
        reset_n = 1'b0;
        step();
        check("rstreq m_read", m_read, 0);
        check("rstreq value", value, 0);
        check("rstreq valid", value_valid, 0);
        check("rstreq err", timeout_err, 0);
        check("rstreq busy", busy, 0);
        reset_n = 1'b1;
        enable  = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
